// File: rtl/reg_wb_scheduler_pkg.sv
// Shared constants and types for the register-file writeback scheduler.
// Optional macro: WB_BYPASS_EN (see reg_wb_scheduler.sv).
package reg_wb_pkg;

    localparam int unsigned NUM_REGS = 32'd32;
    localparam int unsigned ADDR_W   = 32'd5;
    localparam int unsigned DATA_W   = 32'd32;
    localparam int unsigned ZERO_REG = 32'd0;

    // Requester indices; also the bit position of each requester in the grant
    localparam int unsigned REQ_ALU  = 32'd0;
    localparam int unsigned REQ_MEM  = 32'd1;

    // One-hot grant: bit REQ_ALU = ALU, bit REQ_MEM = MEM
    typedef enum logic [1:0] {
        GNT_NONE = 2'b00,
        GNT_ALU  = 2'b01,
        GNT_MEM  = 2'b10
    } grant_t;

endpackage

// File: rtl/reg_wb_scheduler_wb_rr_arbiter.sv
// Two-input writeback arbiter (ALU / MEM) producing a one-hot grant.
// FIXED_PRIO=0: round-robin, pointer moves to the loser only on a contended grant.
// FIXED_PRIO=1: MEM always wins a tie.
module wb_rr_arbiter #(
    parameter int unsigned FIXED_PRIO = 32'd0
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [1:0]         req_i,
    output reg_wb_pkg::grant_t gnt_o
);
    import reg_wb_pkg::*;

    // ptr_q holds the index of the requester that wins the next tie
    logic ptr_q;
    logic ptr_d;

    // Grant selection and next pointer value
    always_comb begin
        gnt_o = GNT_NONE;
        ptr_d = ptr_q;
        case (req_i)
            2'b01: gnt_o = GNT_ALU;
            2'b10: gnt_o = GNT_MEM;
            2'b11: begin
                if (FIXED_PRIO != 32'd0) begin
                    gnt_o = GNT_MEM;
                end else if (ptr_q == 1'(REQ_ALU)) begin
                    gnt_o = GNT_ALU;
                    ptr_d = 1'(REQ_MEM);
                end else begin
                    gnt_o = GNT_MEM;
                    ptr_d = 1'(REQ_ALU);
                end
            end
            default: gnt_o = GNT_NONE;
        endcase
    end

    // Round-robin pointer register, ALU favoured out of reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= 1'(REQ_ALU);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/reg_wb_scheduler.sv
// Register-file write-port scheduler: busy scoreboard for RAW/WAW hazards,
// ALU/MEM writeback arbitration, registered write port for a negedge regfile.
// Optional macro: WB_BYPASS_EN adds forwarding of the in-flight register write
// to the decode sources and removes the stall for a forwarded source.
module reg_wb_scheduler #(
    parameter int unsigned NUM_REGS   = 32'd32,
    parameter int unsigned ADDR_W     = 32'd5,
    parameter int unsigned DATA_W     = 32'd32,
    parameter int unsigned FIXED_PRIO = 32'd0
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic              Issue_Valid,
    input  logic [ADDR_W-1:0] Issue_Dest,
    output logic              Issue_Ready,
    input  logic [ADDR_W-1:0] Src_1,
    input  logic [ADDR_W-1:0] Src_2,
    output logic              Stall,
    input  logic              Alu_Valid,
    input  logic [ADDR_W-1:0] Alu_Reg,
    input  logic [DATA_W-1:0] Alu_Data,
    output logic              Alu_Ready,
    input  logic              Mem_Valid,
    input  logic [ADDR_W-1:0] Mem_Reg,
    input  logic [DATA_W-1:0] Mem_Data,
    output logic              Mem_Ready,
    output logic              Reg_Write,
    output logic [ADDR_W-1:0] Write_Reg,
    output logic [DATA_W-1:0] Write_Data
`ifdef WB_BYPASS_EN
    ,
    output logic              Fwd_Hit_1,
    output logic              Fwd_Hit_2,
    output logic [DATA_W-1:0] Fwd_Data_1,
    output logic [DATA_W-1:0] Fwd_Data_2
`endif
);
    import reg_wb_pkg::*;

    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic [NUM_REGS-1:0] busy_set_s;
    logic [NUM_REGS-1:0] busy_clr_s;
    logic                reg_write_q;
    logic                reg_write_d;
    logic [ADDR_W-1:0]   write_reg_q;
    logic [ADDR_W-1:0]   write_reg_d;
    logic [DATA_W-1:0]   write_data_q;
    logic [DATA_W-1:0]   write_data_d;

    grant_t              gnt_s;
    logic                gnt_any_s;
    logic [ADDR_W-1:0]   gnt_reg_s;
    logic [DATA_W-1:0]   gnt_data_s;
    logic                issue_ready_s;
    logic                issue_fire_s;
    logic                fwd_hit_1_s;
    logic                fwd_hit_2_s;

    wb_rr_arbiter #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_arb (
        .clk_i  (Clock),
        .rst_ni (Reset_n),
        .req_i  ({Mem_Valid, Alu_Valid}),
        .gnt_o  (gnt_s)
    );

    assign Alu_Ready = (gnt_s == GNT_ALU);
    assign Mem_Ready = (gnt_s == GNT_MEM);

    // Steer the granted requester's register and data onto the write path
    always_comb begin
        gnt_any_s  = 1'b0;
        gnt_reg_s  = Alu_Reg;
        gnt_data_s = Alu_Data;
        case (gnt_s)
            GNT_ALU: begin
                gnt_any_s  = 1'b1;
                gnt_reg_s  = Alu_Reg;
                gnt_data_s = Alu_Data;
            end
            GNT_MEM: begin
                gnt_any_s  = 1'b1;
                gnt_reg_s  = Mem_Reg;
                gnt_data_s = Mem_Data;
            end
            default: begin
                gnt_any_s  = 1'b0;
                gnt_reg_s  = Alu_Reg;
                gnt_data_s = Alu_Data;
            end
        endcase
    end

    // Register 0 is never busy, so it never blocks an issue (WAW check)
    assign issue_ready_s = !busy_q[Issue_Dest] || (Issue_Dest == ZERO_IDX);
    assign issue_fire_s  = Issue_Valid && issue_ready_s && (Issue_Dest != ZERO_IDX);
    assign Issue_Ready   = issue_ready_s;

    // Scoreboard next state: clear on grant, set on issue; set wins a collision
    always_comb begin
        busy_clr_s = '0;
        busy_set_s = '0;
        if (gnt_any_s) begin
            busy_clr_s[gnt_reg_s] = 1'b1;
        end else begin
            busy_clr_s = '0;
        end
        if (issue_fire_s) begin
            busy_set_s[Issue_Dest] = 1'b1;
        end else begin
            busy_set_s = '0;
        end
        busy_d = (busy_q & ~busy_clr_s) | busy_set_s;
        busy_d[ZERO_REG] = 1'b0;
    end

    // Write-port next state; index/data hold when nothing is granted
    always_comb begin
        reg_write_d = gnt_any_s && (gnt_reg_s != ZERO_IDX);
        if (gnt_any_s) begin
            write_reg_d  = gnt_reg_s;
            write_data_d = gnt_data_s;
        end else begin
            write_reg_d  = write_reg_q;
            write_data_d = write_data_q;
        end
    end

    // Scoreboard and registered write port
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            busy_q       <= '0;
            reg_write_q  <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
        end else begin
            busy_q       <= busy_d;
            reg_write_q  <= reg_write_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
        end
    end

    assign Reg_Write  = reg_write_q;
    assign Write_Reg  = write_reg_q;
    assign Write_Data = write_data_q;

`ifdef WB_BYPASS_EN
    // A source matching the register being written this cycle is forwarded
    assign fwd_hit_1_s = reg_write_q && (write_reg_q == Src_1) && (Src_1 != ZERO_IDX);
    assign fwd_hit_2_s = reg_write_q && (write_reg_q == Src_2) && (Src_2 != ZERO_IDX);
    assign Fwd_Hit_1   = fwd_hit_1_s;
    assign Fwd_Hit_2   = fwd_hit_2_s;
    assign Fwd_Data_1  = fwd_hit_1_s ? write_data_q : '0;
    assign Fwd_Data_2  = fwd_hit_2_s ? write_data_q : '0;
`else
    assign fwd_hit_1_s = 1'b0;
    assign fwd_hit_2_s = 1'b0;
`endif

    assign Stall = ((Src_1 != ZERO_IDX) && busy_q[Src_1] && !fwd_hit_1_s) ||
                   ((Src_2 != ZERO_IDX) && busy_q[Src_2] && !fwd_hit_2_s);

endmodule

// File: doc/reg_wb_scheduler.md
Name: reg_wb_scheduler

Overview:
- Sequences the register file's single write port in the MIPS core.
- Tracks in-flight destination registers with a 32-bit busy scoreboard and raises stall for RAW/WAW hazards.
- Arbitrates ALU and MEM writebacks onto Reg_Write/Write_Reg/Write_Data, which are registered and stable at the register file's negedge write.

Parameters:
- NUM_REGS, 32, number of architectural registers
- ADDR_W, 5, register index width
- DATA_W, 32, write data width
- FIXED_PRIO, 0, 0 = round-robin between ALU/MEM; 1 = MEM always wins

Ports:
- Clock  input  1  system clock, all state updates on posedge
- Reset_n  input  1  asynchronous active-low reset
- Issue_Valid  input  1  instruction with register destination is issuing
- Issue_Dest  input  ADDR_W  destination register of issuing instruction
- Issue_Ready  output  1  issue accepted this cycle (combinational)
- Src_1, Src_2  input  ADDR_W  source registers of the instruction in decode
- Stall  output  1  RAW hazard on a source (combinational)
- Alu_Valid, Mem_Valid  input  1  writeback request from ALU / MEM
- Alu_Reg, Mem_Reg  input  ADDR_W  writeback destination
- Alu_Data, Mem_Data  input  DATA_W  writeback value
- Alu_Ready, Mem_Ready  output  1  writeback granted this cycle (combinational)
- Reg_Write  output  1  register-file write enable (registered)
- Write_Reg  output  ADDR_W  register-file write index (registered)
- Write_Data  output  DATA_W  register-file write data (registered)

Behaviour:
- Interface: one clock, Clock; reset is asynchronous and active-low, Reset_n.
- Reset values:
  - Busy[31:0] = 0.
  - Reg_Write = 0, Write_Reg = 0, Write_Data = 0.
  - Round-robin pointer points to ALU (ALU wins the first tie).
- Reset mid-operation clears all busy bits and drops any pending write. The write pulse is gone before the next negedge.
- Issue:
  - Issue_Ready = !Busy[Issue_Dest] || Issue_Dest == 0. This is the WAW stall.
  - Issue_Valid && Issue_Ready && Issue_Dest != 0 sets Busy[Issue_Dest] at the next posedge.
- Stall = (Src_1 != 0 && Busy[Src_1]) || (Src_2 != 0 && Busy[Src_2]). Register 0 is never busy.
- Arbitration:
  - Single requester: granted immediately.
  - Both valid with FIXED_PRIO=0: the pointer side wins. The pointer then moves to the loser, and only advances on a contended grant.
  - Both valid with FIXED_PRIO=1: MEM wins.
  - A requester holds Valid/Reg/Data stable until it sees Ready.
- Grant effects:
  - At the next posedge: Reg_Write = (granted Reg != 0), Write_Reg = granted Reg, Write_Data = granted Data.
  - Busy[granted Reg] is cleared at the same posedge.
  - Latency: one cycle, grant to Reg_Write. The register file commits at the following negedge.
  - No grant: Reg_Write = 0 next cycle. Write_Reg/Write_Data hold their last values.
- Writes to register 0 are accepted (Ready=1) but never assert Reg_Write.
- Simultaneous set and clear of the same register in one cycle: the set wins and Busy stays 1. This only arises when the grant clear coincides with a new issue.
- A writeback to a non-busy register is legal. It writes normally and Busy is unchanged (stays 0).
- At most one grant per cycle. A stalled requester sees Ready=0 with no bound other than round-robin fairness (at most 1 cycle of wait under FIXED_PRIO=0).

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined:
  - Adds outputs Fwd_Data_1 and Fwd_Data_2 (DATA_W) and Fwd_Hit_1 and Fwd_Hit_2 (1).
  - When Reg_Write=1 and Write_Reg equals Src_n (nonzero), Fwd_Hit_n=1 and Fwd_Data_n=Write_Data.
  - Stall ignores that source even if Busy is set.
- Undefined: the ports are absent and Stall is exactly as above.

Decomposition:
- Package reg_wb_pkg holds:
  - ADDR_W, DATA_W, NUM_REGS, ZERO_REG=0.
  - Requester index constants REQ_ALU=0, REQ_MEM=1.
  - The grant-encoding typedef.
- One natural sub-module: wb_rr_arbiter, a 2-input round-robin/fixed-priority arbiter producing a one-hot grant. Scoreboard and output registers stay in the top.

Test Plan:
- Reset: drive Reset_n=0 mid-cycle after setting Busy[8] → Busy=0, Reg_Write=0 immediately; Src_1=8 gives Stall=0.
- Issue Dest=8, then Src_1=8 → Stall=1. Then Alu_Valid, Reg=8, Data=0x12345678 → Alu_Ready=1; next cycle Reg_Write=1, Write_Reg=8, Write_Data=0x12345678; Stall drops the cycle after the grant.
- Alu (Reg=9, 0xA) and Mem (Reg=10, 0xB) valid for 3 cycles with FIXED_PRIO=0 → grants ALU, MEM, ALU; Write_Reg sequence 9, 10, 9. With FIXED_PRIO=1 → MEM every cycle.
- Mem writeback to Reg=0 with Data=0xFFFFFFFF → Mem_Ready=1, Reg_Write stays 0; Issue_Dest=0 → Issue_Ready=1, no busy bit set.
- Same-cycle grant to reg 17 plus Issue_Dest=17 → Busy[17]=1 after the edge; a second issue to 17 sees Issue_Ready=0.
- With WB_BYPASS_EN: Reg_Write=1, Write_Reg=18, Busy[18]=1, Src_2=18 → Stall=0, Fwd_Hit_2=1, Fwd_Data_2=Write_Data.
